// File: rtl/rmt_pkg.sv
// rmt_pkg: shared types and constants for the rmt_match_router ingress classifier.
//   state_e           - frame FSM encoding (IDLE / PASS / DROP)
//   ETHERTYPE_IPV4_LE - EtherType 0x0800 as it appears in raw lane order
//   ENT_*             - match table entry field widths {valid, key, dest}
//   entry_hit()       - single-entry match predicate used by the lookup
package rmt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  localparam logic [15:0] ETHERTYPE_IPV4_LE = 16'h0008;

  localparam int ENT_VALID_W = 1;
  localparam int ENT_KEY_W   = 16;

  function automatic logic entry_hit(input logic                 ent_valid,
                                     input logic [ENT_KEY_W-1:0] ent_key,
                                     input logic [ENT_KEY_W-1:0] lkp_key);
    return ent_valid && (ent_key == lkp_key);
  endfunction

endpackage

// File: rtl/rmt_match_table.sv
// rmt_match_table: runtime-programmable function-type match table.
//   clk, rst_n        - clock, asynchronous active-low reset (all entries invalid)
//   wr_en/wr_addr     - write strobe and entry index
//   wr_valid/key/dest - entry contents; a write becomes visible the next cycle
//   lkp_key           - function-type key from the current first beat
//   lkp_hit/lkp_dest  - combinational result, lowest-index matching entry wins
module rmt_match_table
  import rmt_pkg::*;
#(
  parameter int TABLE_DEPTH = 8,
  parameter int DEST_WIDTH  = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en,
  input  logic [$clog2(TABLE_DEPTH)-1:0] wr_addr,
  input  logic                           wr_valid,
  input  logic [ENT_KEY_W-1:0]           wr_key,
  input  logic [DEST_WIDTH-1:0]          wr_dest,
  input  logic [ENT_KEY_W-1:0]           lkp_key,
  output logic                           lkp_hit,
  output logic [DEST_WIDTH-1:0]          lkp_dest
);

  localparam int ADDR_W = $clog2(TABLE_DEPTH);

  typedef struct packed {
    logic [ENT_VALID_W-1:0] valid;
    logic [ENT_KEY_W-1:0]   key;
    logic [DEST_WIDTH-1:0]  dest;
  } entry_t;

  entry_t tbl_q [TABLE_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TABLE_DEPTH; i++) begin
        tbl_q[i[ADDR_W-1:0]] <= '0;
      end
    end else if (wr_en) begin
      tbl_q[wr_addr] <= '{valid: wr_valid, key: wr_key, dest: wr_dest};
    end
  end

  // Scan from the top down so the lowest matching index is the last one assigned.
  always_comb begin
    lkp_hit  = 1'b0;
    lkp_dest = '0;
    for (int i = TABLE_DEPTH - 1; i >= 0; i--) begin
      if (entry_hit(tbl_q[i[ADDR_W-1:0]].valid, tbl_q[i[ADDR_W-1:0]].key, lkp_key)) begin
        lkp_hit  = 1'b1;
        lkp_dest = tbl_q[i[ADDR_W-1:0]].dest;
      end
    end
  end

endmodule

// File: rtl/rmt_match_router.sv
// rmt_match_router: AXI-Stream ingress classifier/router.
//   clk, rst_n       - clock, asynchronous active-low reset
//   s_axis_*         - ingress stream (header parsed from the first beat)
//   m_axis_*         - egress stream through a single register slice, with tdest
//   cfg_wr_*         - match table write port
//   stat_pass_pkts   - forwarded packet count (wraps)
//   stat_drop_pkts   - dropped packet count (wraps)
// The first beat is checked for EtherType/delimiter and its function type is
// looked up; the resulting forward/drop decision and tdest hold for the packet.
module rmt_match_router
  import rmt_pkg::*;
#(
  parameter int          DATA_WIDTH   = 512,
  parameter int          KEEP_WIDTH   = DATA_WIDTH / 8,
  parameter int          USER_WIDTH   = 1,
  parameter int          DEST_WIDTH   = 4,
  parameter int          TABLE_DEPTH  = 8,
  parameter int          ETYPE_OFFSET = 12,
  parameter int          DELIM_OFFSET = 42,
  parameter logic [15:0] DELIM_VALUE  = 16'hF0E1,
  parameter int          FUNC_OFFSET  = 44,
  parameter int          MISS_DROP    = 1,
  parameter int          DEFAULT_DEST = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [DATA_WIDTH-1:0]          s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]          s_axis_tkeep,
  input  logic                           s_axis_tvalid,
  output logic                           s_axis_tready,
  input  logic                           s_axis_tlast,
  input  logic [USER_WIDTH-1:0]          s_axis_tuser,
  output logic [DATA_WIDTH-1:0]          m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]          m_axis_tkeep,
  output logic                           m_axis_tvalid,
  input  logic                           m_axis_tready,
  output logic                           m_axis_tlast,
  output logic [USER_WIDTH-1:0]          m_axis_tuser,
  output logic [DEST_WIDTH-1:0]          m_axis_tdest,
  input  logic                           cfg_wr_en,
  input  logic [$clog2(TABLE_DEPTH)-1:0] cfg_wr_addr,
  input  logic                           cfg_wr_valid,
  input  logic [15:0]                    cfg_wr_key,
  input  logic [DEST_WIDTH-1:0]          cfg_wr_dest,
  output logic [31:0]                    stat_pass_pkts,
  output logic [31:0]                    stat_drop_pkts
);

  localparam logic [DEST_WIDTH-1:0] DFLT_DEST = DEST_WIDTH'(DEFAULT_DEST);

  state_e                  state_q, state_d;
  logic [DEST_WIDTH-1:0]   pkt_dest_q, pkt_dest_d;
  logic [31:0]             pass_cnt_q, pass_cnt_d;
  logic [31:0]             drop_cnt_q, drop_cnt_d;

  logic [DATA_WIDTH-1:0]   tdata_p1;
  logic [KEEP_WIDTH-1:0]   tkeep_p1;
  logic                    tlast_p1;
  logic [USER_WIDTH-1:0]   tuser_p1;
  logic [DEST_WIDTH-1:0]   tdest_p1;
  logic                    vld_p1;

  logic [15:0]             func_key;
  logic                    hdr_ok;
  logic                    hit;
  logic [DEST_WIDTH-1:0]   hit_dest;
  logic                    fwd_dec;
  logic [DEST_WIDTH-1:0]   dec_dest;
  logic                    slot_free;
  logic                    s_ready;
  logic                    s_acc;
  logic                    fwd_beat;
  logic [DEST_WIDTH-1:0]   beat_dest;

  // ---- p0: first-beat header check and table lookup (combinational) ----
  assign func_key = s_axis_tdata[FUNC_OFFSET*8 +: 16];
  assign hdr_ok   = (s_axis_tdata[ETYPE_OFFSET*8 +: 16] == ETHERTYPE_IPV4_LE) &&
                    (s_axis_tdata[DELIM_OFFSET*8 +: 16] == DELIM_VALUE);

  rmt_match_table #(
    .TABLE_DEPTH (TABLE_DEPTH),
    .DEST_WIDTH  (DEST_WIDTH)
  ) u_table (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (cfg_wr_en),
    .wr_addr  (cfg_wr_addr),
    .wr_valid (cfg_wr_valid),
    .wr_key   (cfg_wr_key),
    .wr_dest  (cfg_wr_dest),
    .lkp_key  (func_key),
    .lkp_hit  (hit),
    .lkp_dest (hit_dest)
  );

  assign fwd_dec   = hdr_ok && (hit || (MISS_DROP == 0));
  assign dec_dest  = hit ? hit_dest : DFLT_DEST;
  assign slot_free = !vld_p1 || m_axis_tready;

  // Dropped beats never enter the slice, so they are sunk unconditionally;
  // ready never looks at s_axis_tvalid.
  always_comb begin
    state_d    = state_q;
    pkt_dest_d = pkt_dest_q;
    pass_cnt_d = pass_cnt_q;
    drop_cnt_d = drop_cnt_q;
    s_ready    = slot_free;
    fwd_beat   = 1'b0;
    beat_dest  = pkt_dest_q;
    unique case (state_q)
      ST_IDLE: begin
        beat_dest = dec_dest;
        fwd_beat  = fwd_dec;
        s_ready   = fwd_dec ? slot_free : 1'b1;
        if (s_axis_tvalid && s_ready) begin
          pkt_dest_d = dec_dest;
          if (fwd_dec) pass_cnt_d = pass_cnt_q + 32'd1;
          else         drop_cnt_d = drop_cnt_q + 32'd1;
          if (!s_axis_tlast) state_d = fwd_dec ? ST_PASS : ST_DROP;
        end
      end
      ST_PASS: begin
        fwd_beat = 1'b1;
        s_ready  = slot_free;
        if (s_axis_tvalid && s_ready && s_axis_tlast) state_d = ST_IDLE;
      end
      ST_DROP: begin
        s_ready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign s_axis_tready = s_ready;
  assign s_acc         = s_axis_tvalid && s_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pkt_dest_q <= '0;
      pass_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pkt_dest_q <= pkt_dest_d;
      pass_cnt_q <= pass_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // ---- p1: egress register slice ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      tdata_p1 <= '0;
      tkeep_p1 <= '0;
      tlast_p1 <= 1'b0;
      tuser_p1 <= '0;
      tdest_p1 <= '0;
    end else if (slot_free) begin
      vld_p1 <= s_acc && fwd_beat;
      if (s_acc && fwd_beat) begin
        tdata_p1 <= s_axis_tdata;
        tkeep_p1 <= s_axis_tkeep;
        tlast_p1 <= s_axis_tlast;
        tuser_p1 <= s_axis_tuser;
        tdest_p1 <= beat_dest;
      end
    end
  end

  assign m_axis_tvalid  = vld_p1;
  assign m_axis_tdata   = tdata_p1;
  assign m_axis_tkeep   = tkeep_p1;
  assign m_axis_tlast   = tlast_p1;
  assign m_axis_tuser   = tuser_p1;
  assign m_axis_tdest   = tdest_p1;
  assign stat_pass_pkts = pass_cnt_q;
  assign stat_drop_pkts = drop_cnt_q;

endmodule

// File: tb/tb_rmt_match_router.sv
// tb_rmt_match_router: directed bench for rmt_match_router.
// Two instances: dut (MISS_DROP=1) and dut_nd (MISS_DROP=0, DEFAULT_DEST=2),
// sharing data, m_tready and config; each has its own s_tvalid.
module tb_rmt_match_router;

  localparam int DW = 512;
  localparam int KW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [DW-1:0] s_tdata;
  logic [KW-1:0] s_tkeep;
  logic          s_tvalid, s_tready, s_tlast;
  logic [0:0]    s_tuser;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tvalid, m_tready, m_tlast;
  logic [0:0]    m_tuser;
  logic [3:0]    m_tdest;
  logic          cfg_wr_en, cfg_wr_valid;
  logic [2:0]    cfg_wr_addr;
  logic [15:0]   cfg_wr_key;
  logic [3:0]    cfg_wr_dest;
  logic [31:0]   pass_cnt, drop_cnt;

  logic          nd_s_tvalid, nd_s_tready;
  logic [DW-1:0] nd_m_tdata;
  logic [KW-1:0] nd_m_tkeep;
  logic          nd_m_tvalid, nd_m_tlast;
  logic [0:0]    nd_m_tuser;
  logic [3:0]    nd_m_tdest;
  logic [31:0]   nd_pass_cnt, nd_drop_cnt;

  rmt_match_router dut (
    .clk (clk), .rst_n (rst_n),
    .s_axis_tdata (s_tdata), .s_axis_tkeep (s_tkeep), .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready), .s_axis_tlast (s_tlast), .s_axis_tuser (s_tuser),
    .m_axis_tdata (m_tdata), .m_axis_tkeep (m_tkeep), .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready), .m_axis_tlast (m_tlast), .m_axis_tuser (m_tuser),
    .m_axis_tdest (m_tdest),
    .cfg_wr_en (cfg_wr_en), .cfg_wr_addr (cfg_wr_addr), .cfg_wr_valid (cfg_wr_valid),
    .cfg_wr_key (cfg_wr_key), .cfg_wr_dest (cfg_wr_dest),
    .stat_pass_pkts (pass_cnt), .stat_drop_pkts (drop_cnt)
  );

  rmt_match_router #(.MISS_DROP(0), .DEFAULT_DEST(2)) dut_nd (
    .clk (clk), .rst_n (rst_n),
    .s_axis_tdata (s_tdata), .s_axis_tkeep (s_tkeep), .s_axis_tvalid (nd_s_tvalid),
    .s_axis_tready (nd_s_tready), .s_axis_tlast (s_tlast), .s_axis_tuser (s_tuser),
    .m_axis_tdata (nd_m_tdata), .m_axis_tkeep (nd_m_tkeep), .m_axis_tvalid (nd_m_tvalid),
    .m_axis_tready (m_tready), .m_axis_tlast (nd_m_tlast), .m_axis_tuser (nd_m_tuser),
    .m_axis_tdest (nd_m_tdest),
    .cfg_wr_en (cfg_wr_en), .cfg_wr_addr (cfg_wr_addr), .cfg_wr_valid (cfg_wr_valid),
    .cfg_wr_key (cfg_wr_key), .cfg_wr_dest (cfg_wr_dest),
    .stat_pass_pkts (nd_pass_cnt), .stat_drop_pkts (nd_drop_cnt)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic          user;
  } beat_t;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic          user;
    logic [3:0]    dest;
  } obeat_t;

  beat_t  inq[$];
  obeat_t expq[$];
  obeat_t outq[$];

  int n_vec  = 0;
  int n_miss = 0;
  int first_in, first_out, rdy_low, stab_err;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] hdr(input logic [15:0] et, input logic [15:0] fn,
                                        input logic [7:0] tag);
    logic [DW-1:0] d;
    d = '0;
    d[7:0]       = tag;
    d[12*8 +: 16] = et;
    d[42*8 +: 16] = 16'hF0E1;
    d[44*8 +: 16] = fn;
    d[60*8 +: 8]  = 8'hA5;
    return d;
  endfunction

  // Queue a frame for sending; when fwd is set also queue its expected egress.
  task automatic add_frame(input logic [15:0] et, input logic [15:0] fn, input int nb,
                           input logic [7:0] tag, input bit fwd, input logic [3:0] dst);
    beat_t  b;
    obeat_t o;
    for (int i = 0; i < nb; i++) begin
      if (i == 0) b.data = hdr(et, fn, tag);
      else begin
        b.data      = {64{tag}};
        b.data[7:0] = 8'(i);
      end
      b.keep = '1;
      b.last = (i == nb - 1);
      b.user = i[0];
      inq.push_back(b);
      if (fwd) begin
        o.data = b.data; o.last = b.last; o.user = b.user; o.dest = dst;
        expq.push_back(o);
      end
    end
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic v, input logic [15:0] k,
                           input logic [3:0] d);
    cfg_wr_en = 1'b1; cfg_wr_addr = a; cfg_wr_valid = v; cfg_wr_key = k; cfg_wr_dest = d;
    @(posedge clk); #1;
    cfg_wr_en = 1'b0;
  endtask

  // mode: 0 = m_tready high, 1 = toggle 1010.., 2 = m_tready low
  task automatic run(input bit sel, input int mode, input bit sink, input bit mid_wr,
                     input int max_cyc);
    int     n, drain;
    bit     hold_v, acc_any, wr_done;
    obeat_t held, cur;
    logic   rdy, ov;
    n = 0; drain = 0; hold_v = 0; acc_any = 0; wr_done = 0; held = '0;
    first_in = -1; first_out = -1; rdy_low = 0; stab_err = 0;
    outq.delete();
    while (n < max_cyc && !(inq.size() == 0 && drain >= 3)) begin
      if (inq.size() > 0) begin
        s_tdata = inq[0].data; s_tkeep = inq[0].keep;
        s_tlast = inq[0].last; s_tuser = inq[0].user;
      end
      s_tvalid    = !sel && (inq.size() > 0);
      nd_s_tvalid = sel && (inq.size() > 0);
      m_tready    = (mode == 0) || (mode == 1 && (n % 2 == 0));
      if (mid_wr && acc_any && !wr_done) begin
        cfg_wr_en = 1'b1; cfg_wr_addr = 3'd0; cfg_wr_valid = 1'b1;
        cfg_wr_key = 16'h0001; cfg_wr_dest = 4'd3; wr_done = 1;
      end else cfg_wr_en = 1'b0;
      @(negedge clk);
      rdy      = sel ? nd_s_tready : s_tready;
      ov       = sel ? nd_m_tvalid : m_tvalid;
      cur.data = sel ? nd_m_tdata : m_tdata;
      cur.last = sel ? nd_m_tlast : m_tlast;
      cur.user = sel ? nd_m_tuser[0] : m_tuser[0];
      cur.dest = sel ? nd_m_tdest : m_tdest;
      if (hold_v && (!ov || cur != held)) stab_err++;
      hold_v = ov && !m_tready;
      held   = cur;
      if (ov && m_tready) begin
        outq.push_back(cur);
        if (first_out < 0) first_out = n;
      end
      if (inq.size() > 0) begin
        if (sink && !rdy) rdy_low++;
        if (rdy) begin
          void'(inq.pop_front());
          acc_any = 1;
          if (first_in < 0) first_in = n;
        end
      end else drain++;
      @(posedge clk); #1;
      n++;
    end
    s_tvalid = 1'b0; nd_s_tvalid = 1'b0; cfg_wr_en = 1'b0;
  endtask

  task automatic check_out(input string t);
    chk({t, "_nbeats"}, DW'(outq.size()), DW'(expq.size()));
    chk({t, "_sent"}, DW'(inq.size()), '0);
    for (int i = 0; i < expq.size() && i < outq.size(); i++) begin
      chk($sformatf("%s_data%0d", t, i), outq[i].data, expq[i].data);
      chk($sformatf("%s_last%0d", t, i), DW'(outq[i].last), DW'(expq[i].last));
      chk($sformatf("%s_user%0d", t, i), DW'(outq[i].user), DW'(expq[i].user));
      chk($sformatf("%s_dest%0d", t, i), DW'(outq[i].dest), DW'(expq[i].dest));
    end
    expq.delete();
    inq.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    s_tdata = '0; s_tkeep = '0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = '0;
    nd_s_tvalid = 1'b0; m_tready = 1'b1;
    cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_valid = 1'b0; cfg_wr_key = '0; cfg_wr_dest = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // reset state
    chk("rst_mvalid", DW'(m_tvalid), '0);
    chk("rst_mdata", m_tdata, '0);
    chk("rst_mdest", DW'(m_tdest), '0);
    chk("rst_pass", DW'(pass_cnt), '0);
    chk("rst_drop", DW'(drop_cnt), '0);
    chk("rst_sready", DW'(s_tready), DW'(1));

    // T1: hit on entry 0 -> dest 1, 3 beats, 1-cycle latency
    cfg_write(3'd0, 1'b1, 16'h0001, 4'd1);
    add_frame(16'h0008, 16'h0001, 3, 8'h11, 1, 4'd1);
    run(0, 0, 0, 0, 40);
    chk("t1_latency", DW'(first_out - first_in), DW'(1));
    check_out("t1");
    chk("t1_pass", DW'(pass_cnt), DW'(1));

    // T2a: miss with MISS_DROP=1 -> dropped, always ready
    add_frame(16'h0008, 16'h0005, 3, 8'h22, 0, 4'd0);
    run(0, 0, 1, 0, 40);
    chk("t2_rdy_low", DW'(rdy_low), '0);
    check_out("t2");
    chk("t2_drop", DW'(drop_cnt), DW'(1));
    chk("t2_pass", DW'(pass_cnt), DW'(1));

    // T2b: miss with MISS_DROP=0 -> forwarded to DEFAULT_DEST=2
    add_frame(16'h0008, 16'h0005, 3, 8'h23, 1, 4'd2);
    run(1, 0, 0, 0, 40);
    check_out("t2nd");
    chk("t2nd_pass", DW'(nd_pass_cnt), DW'(1));
    chk("t2nd_drop", DW'(nd_drop_cnt), '0);

    // T3: bad EtherType single beat dropped, next frame right behind forwarded
    add_frame(16'hDD86, 16'h0001, 1, 8'h33, 0, 4'd0);
    add_frame(16'h0008, 16'h0001, 1, 8'h34, 1, 4'd1);
    run(0, 0, 0, 0, 40);
    chk("t3_back2back", DW'(first_out), DW'(2));
    check_out("t3");
    chk("t3_drop", DW'(drop_cnt), DW'(2));
    chk("t3_pass", DW'(pass_cnt), DW'(2));

    // T4: 5 beats under 1010 backpressure
    add_frame(16'h0008, 16'h0001, 5, 8'h44, 1, 4'd1);
    run(0, 1, 0, 0, 60);
    chk("t4_stable", DW'(stab_err), '0);
    check_out("t4");
    chk("t4_pass", DW'(pass_cnt), DW'(3));

    // T5: entry 0 rewritten to dest 3 mid-packet; next packet picks it up
    add_frame(16'h0008, 16'h0001, 4, 8'h55, 1, 4'd1);
    run(0, 0, 0, 1, 40);
    check_out("t5a");
    add_frame(16'h0008, 16'h0001, 1, 8'h56, 1, 4'd3);
    run(0, 0, 0, 0, 40);
    check_out("t5b");
    // priority: entries 2 and 5 share key 0007, entry 2 wins
    cfg_write(3'd5, 1'b1, 16'h0007, 4'd6);
    cfg_write(3'd2, 1'b1, 16'h0007, 4'd5);
    add_frame(16'h0008, 16'h0007, 2, 8'h57, 1, 4'd5);
    run(0, 0, 0, 0, 40);
    check_out("t5c");
    chk("t5_pass", DW'(pass_cnt), DW'(6));
    chk("t5_drop", DW'(drop_cnt), DW'(2));

    // T6: async reset mid-packet with m_tvalid held high
    add_frame(16'h0008, 16'h0001, 4, 8'h66, 0, 4'd0);
    run(0, 2, 0, 0, 3);
    chk("t6_pre_mvalid", DW'(m_tvalid), DW'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("t6_mvalid_async", DW'(m_tvalid), '0);
    chk("t6_mdata_async", m_tdata, '0);
    chk("t6_pass_clr", DW'(pass_cnt), '0);
    chk("t6_drop_clr", DW'(drop_cnt), '0);
    inq.delete();
    expq.delete();
    m_tready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    add_frame(16'h0008, 16'h0001, 2, 8'h67, 0, 4'd0);
    run(0, 0, 1, 0, 40);
    chk("t6_rdy_low", DW'(rdy_low), '0);
    check_out("t6");
    chk("t6_drop", DW'(drop_cnt), DW'(1));
    chk("t6_pass", DW'(pass_cnt), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/rmt_match_router.md
Name: rmt_match_router

Overview:
- Next-generation ingress classifier/router for the app-block AXI-Stream datapath, placed between the MAC-side RX stream and the per-function handlers.
- Parses the header from the first beat of each frame and checks EtherType and the custom delimiter. It then looks up the 16-bit function type in a runtime-programmable match table.
- Forwards the frame with a per-packet tdest, or drops it.
- Adds over the previous generation: correct AXI-Stream backpressure, configurable table depth and field offsets, a miss policy, and statistics counters.

Parameters:
- DATA_WIDTH, 512, tdata width in bits; must be ≥ (FUNC_OFFSET+2)*8.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
- USER_WIDTH, 1, tuser width; passed through unchanged.
- DEST_WIDTH, 4, tdest width.
- TABLE_DEPTH, 8, number of match entries; power of 2, 2..32.
- ETYPE_OFFSET, 12, byte offset of EtherType.
- DELIM_OFFSET, 42, byte offset of the delimiter.
- DELIM_VALUE, 16'hF0E1, required delimiter, compared as raw lane bytes.
- FUNC_OFFSET, 44, byte offset of the function type.
- MISS_DROP, 1, behaviour on a table miss: 1 = drop, 0 = forward to DEFAULT_DEST.
- DEFAULT_DEST, 0, tdest used on a miss when MISS_DROP=0.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- s_axis_tdata/tkeep/tvalid/tready/tlast/tuser  in/in/in/out/in/in  DATA_WIDTH/KEEP_WIDTH/1/1/1/USER_WIDTH  ingress stream.
- m_axis_tdata/tkeep/tvalid/tready/tlast/tuser  out/out/out/in/out/out  same widths  egress stream.
- m_axis_tdest  out  DEST_WIDTH  route for the current packet.
- cfg_wr_en  in  1  table write strobe.
- cfg_wr_addr  in  $clog2(TABLE_DEPTH)  entry index.
- cfg_wr_valid  in  1  entry enable.
- cfg_wr_key  in  16  function-type key, in raw lane order.
- cfg_wr_dest  in  DEST_WIDTH  destination for a hit.
- stat_pass_pkts  out  32  count of forwarded packets.
- stat_drop_pkts  out  32  count of dropped packets.

Behaviour:
- Reset (async assert, sync release):
  - m_axis_tvalid=0; tdata/tkeep/tlast/tuser/tdest=0.
  - All table entries invalid; state IDLE; both counters 0.
  - A packet in flight at reset is not recovered: its remaining beats are parsed as a new header and normally fail the header check, so they are dropped.
- Header check on the first beat:
  - hdr_ok = tdata[ETYPE_OFFSET*8+:16]==16'h0008 (wire 0x0800) && tdata[DELIM_OFFSET*8+:16]==DELIM_VALUE.
  - The func key is tdata[FUNC_OFFSET*8+:16].
- Lookup:
  - Combinational over all entries; the lowest-index valid entry whose key matches wins.
  - The table is sampled at first-beat acceptance.
  - A cfg write in the same cycle takes effect from the next cycle.
  - Writes while a packet is in flight never change that packet's tdest.
- Decision on a first beat:
  - Forward when hdr_ok and (hit or !MISS_DROP); otherwise drop.
  - tdest = hit ? entry dest : DEFAULT_DEST. tdest is latched and held for every beat of the packet.
- Output stage:
  - A single register slice; latency is 1 cycle from s-accept to m_axis_tvalid.
  - s_axis_tready = !m_axis_tvalid || m_axis_tready in the IDLE and PASS states.
  - s_axis_tready = 1 in the DROP state, and when a first beat is dropped in IDLE.
  - tready is combinational from m_axis_tready only, never from s_axis_tvalid.
  - While m_axis_tvalid=1 && !m_axis_tready, all m_* outputs stay stable.
  - Full throughput: 1 beat/cycle with m_axis_tready held high.
- FSM:
  - IDLE: on an accepted first beat with tlast=1, the packet is complete and stays in IDLE. With tlast=0, go to PASS (forward) or DROP.
  - PASS: accept and forward beats; an accepted tlast returns to IDLE.
  - DROP: sink beats; an accepted tlast returns to IDLE.
  - No transition happens without an accepted beat (tvalid&&tready). Bubbles in s_axis_tvalid hold the state.
- Counters:
  - Incremented by 1 at the decision beat: pass on forward, drop on drop.
  - Both wrap modulo 2^32.
  - Never affected by cfg writes.
- tkeep/tuser are passed through unmodified. A tkeep that is short on the first beat is not checked.

Decomposition:
- Package rmt_pkg:
  - state encoding IDLE/PASS/DROP;
  - ETHERTYPE_IPV4_LE=16'h0008;
  - a table entry struct/field-width constants {valid, key[15:0], dest}.
- Sub-module rmt_match_table:
  - holds the register array, write port and priority lookup;
  - inputs key, outputs hit/dest.
- The top level owns the FSM, the output slice and the counters.

Test Plan:
- Table entry 0 = {key 16'h0001, dest 1}; 3-beat UDP frame, delimiter F0E1, func 0001, m_tready=1 → 3 beats out, 1 cycle late, tdest=1 on all beats, stat_pass_pkts=1.
- Same frame with func 0005 and MISS_DROP=1 → no m_axis_tvalid, s_axis_tready=1 throughout, stat_drop_pkts=1. With MISS_DROP=0 and DEFAULT_DEST=2 → forwarded with tdest=2.
- EtherType 16'hDD86 (wire 0x86DD), single-beat tlast=1 → dropped; FSM stays IDLE; the next valid frame on the following cycle is forwarded.
- Backpressure: toggle m_tready 1010… on a 5-beat frame → all 5 beats delivered in order; data is stable while stalled; no beat duplicated or lost.
- A cfg_wr changing entry 0 to dest 3 mid-packet → current packet keeps tdest=1; the next packet gets tdest=3. Entries 2 and 5 both keyed 0007 → the dest of entry 2 wins.
- Assert rst_n=0 asynchronously mid-packet while m_axis_tvalid=1 → m_axis_tvalid drops immediately; counters and table are cleared; after release, a fresh frame is dropped as a table miss (MISS_DROP=1).
